// File: rtl/aic_pkg.sv
// rtl/aic_pkg.sv - shared FSM encoding, MixColumns coefficients and GF(2^8) helper
package aic_pkg;

   localparam int COL_BYTES = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_FINISH = 2'd3
   } aic_state_e;

   // Element [3] is the most significant byte, i.e. a0 of the column.
   typedef logic [COL_BYTES-1:0][7:0] aic_col_t;

   localparam logic [7:0] INV_COEFF [COL_BYTES] = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
   localparam logic [7:0] FWD_COEFF [COL_BYTES] = '{8'h02, 8'h03, 8'h01, 8'h01};

   // Low byte of the AES reduction polynomial 0x11B.
   localparam logic [7:0] GF_POLY_LO = 8'h1B;

   function automatic logic [7:0] gf_xtime(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? GF_POLY_LO : 8'h00);
   endfunction

endpackage

// File: rtl/aic_multiplier.sv
// rtl/aic_multiplier.sv - constant-time GF(2^8) multiplier, two multiplier bits per clock
module aic_multiplier
   import aic_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   output logic [7:0] p_o,
   output logic       done_o
);

   logic [7:0] a_q, a_d;
   logic [7:0] b_q, b_d;
   logic [7:0] p_q, p_d;
   logic [1:0] cnt_q, cnt_d;
   logic       run_q, run_d;
   logic       done_q, done_d;

   logic       load;
   logic [7:0] src_a, src_b, src_p;
   logic [7:0] p_mid, a_mid;

   // Shift-and-add over two multiplier bits per edge; the start edge does the first pair,
   // so every product takes exactly four edges regardless of operand values.
   always_comb begin
      load   = start_i & ~run_q;
      src_a  = load ? a_i : a_q;
      src_b  = load ? b_i : b_q;
      src_p  = load ? 8'h00 : p_q;
      p_mid  = src_p ^ (src_b[0] ? src_a : 8'h00);
      a_mid  = gf_xtime(src_a);
      a_d    = a_q;
      b_d    = b_q;
      p_d    = p_q;
      cnt_d  = cnt_q;
      run_d  = run_q;
      done_d = 1'b0;
      if (load || run_q) begin
         p_d    = p_mid ^ (src_b[1] ? a_mid : 8'h00);
         a_d    = gf_xtime(a_mid);
         b_d    = {2'b00, src_b[7:2]};
         cnt_d  = load ? 2'd1 : cnt_q + 2'd1;
         run_d  = load ? 1'b1 : (cnt_q != 2'd3);
         done_d = run_q && (cnt_q == 2'd3);
      end
   end

   // Operand, partial product and sequencing registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         a_q    <= 8'h00;
         b_q    <= 8'h00;
         p_q    <= 8'h00;
         cnt_q  <= 2'd0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         p_q    <= p_d;
         cnt_q  <= cnt_d;
         run_q  <= run_d;
         done_q <= done_d;
      end
   end

   assign p_o    = p_q;
   assign done_o = done_q;

endmodule

// File: rtl/aic_mixcol_engine.sv
// rtl/aic_mixcol_engine.sv - sequential (Inv)MixColumns column engine over aic_multiplier
module aic_mixcol_engine
   import aic_pkg::*;
#(
   parameter bit INVERSE = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] col_in,
   output logic [31:0] col_out,
   output logic        busy,
   output logic        done
);

   aic_state_e  state_q, state_d;
   aic_col_t    col_q, col_d;
   aic_col_t    shadow_q, shadow_d;
   logic [31:0] col_out_q, col_out_d;
   logic [7:0]  acc_q, acc_d;
   logic [1:0]  i_q, i_d;
   logic [1:0]  j_q, j_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        mul_start_q, mul_start_d;
   logic [7:0]  mul_in_q, mul_in_d;
   logic [7:0]  coeff_q, coeff_d;

   logic [7:0]  mul_result;
   logic        mul_done;
   logic [7:0]  acc_next;
   logic [1:0]  lane_next;

   function automatic logic [7:0] coeff_of(input logic [1:0] jj);
      return INVERSE ? INV_COEFF[jj] : FWD_COEFF[jj];
   endfunction

   aic_multiplier u_mul (
      .clk_i   (clk),
      .rst_i   (~rst),
      .start_i (mul_start_q),
      .a_i     (mul_in_q),
      .b_i     (coeff_q),
      .p_o     (mul_result),
      .done_o  (mul_done)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // Next state: one ISSUE/WAIT pair per product, FINISH after the 16th product.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_ISSUE;
         ST_ISSUE:  state_d = ST_WAIT;
         ST_WAIT:   if (mul_done) state_d = (i_q == 2'd3 && j_q == 2'd3) ? ST_FINISH : ST_ISSUE;
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Datapath next values; operands for the next product are registered on the edge that
   // enters ISSUE so the multiplier sees a stable start pulse and operands during ISSUE.
   always_comb begin
      col_d       = col_q;
      shadow_d    = shadow_q;
      col_out_d   = col_out_q;
      acc_d       = acc_q;
      i_d         = i_q;
      j_d         = j_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      mul_start_d = 1'b0;
      mul_in_d    = mul_in_q;
      coeff_d     = coeff_q;
      acc_next    = ((j_q == 2'd0) ? 8'h00 : acc_q) ^ mul_result;
      lane_next   = 2'd0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               col_d       = col_in;
               busy_d      = 1'b1;
               i_d         = 2'd0;
               j_d         = 2'd0;
               acc_d       = 8'h00;
               mul_start_d = 1'b1;
               mul_in_d    = col_in[31:24];
               coeff_d     = coeff_of(2'd0);
            end
         end
         ST_WAIT: begin
            if (mul_done) begin
               acc_d = acc_next;
               if (j_q != 2'd3) begin
                  j_d         = j_q + 2'd1;
                  lane_next   = i_q + j_q + 2'd1;
                  mul_start_d = 1'b1;
                  mul_in_d    = col_q[2'd3 - lane_next];
                  coeff_d     = coeff_of(j_q + 2'd1);
               end else begin
                  shadow_d[2'd3 - i_q] = acc_next;
                  if (i_q != 2'd3) begin
                     i_d         = i_q + 2'd1;
                     j_d         = 2'd0;
                     lane_next   = i_q + 2'd1;
                     mul_start_d = 1'b1;
                     mul_in_d    = col_q[2'd3 - lane_next];
                     coeff_d     = coeff_of(2'd0);
                  end
               end
            end
         end
         ST_FINISH: begin
            col_out_d = shadow_q;
            done_d    = 1'b1;
            busy_d    = 1'b0;
         end
         default: ;
      endcase
   end

   // Datapath registers; reset clears everything so an aborted column leaves no trace.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q       <= '0;
         shadow_q    <= '0;
         col_out_q   <= 32'h0;
         acc_q       <= 8'h00;
         i_q         <= 2'd0;
         j_q         <= 2'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         mul_start_q <= 1'b0;
         mul_in_q    <= 8'h00;
         coeff_q     <= 8'h00;
      end else begin
         col_q       <= col_d;
         shadow_q    <= shadow_d;
         col_out_q   <= col_out_d;
         acc_q       <= acc_d;
         i_q         <= i_d;
         j_q         <= j_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         mul_start_q <= mul_start_d;
         mul_in_q    <= mul_in_d;
         coeff_q     <= coeff_d;
      end
   end

   assign col_out = col_out_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_aic_mixcol_engine.sv
// tb/tb_aic_mixcol_engine.sv - scoreboard bench for both engine variants
module tb_aic_mixcol_engine;

   logic        clk;
   logic        rst;
   logic        start_inv, start_fwd;
   logic [31:0] col_in_inv, col_in_fwd;
   logic [31:0] col_out_inv, col_out_fwd;
   logic        busy_inv, busy_fwd;
   logic        done_inv, done_fwd;

   int checks;
   int failures;

   logic [31:0] q_inv[$];
   logic [31:0] q_fwd[$];
   logic        prev_done_inv, prev_done_fwd;

   aic_mixcol_engine #(.INVERSE(1'b1)) u_inv (
      .clk     (clk),
      .rst     (rst),
      .start   (start_inv),
      .col_in  (col_in_inv),
      .col_out (col_out_inv),
      .busy    (busy_inv),
      .done    (done_inv)
   );

   aic_mixcol_engine #(.INVERSE(1'b0)) u_fwd (
      .clk     (clk),
      .rst     (rst),
      .start   (start_fwd),
      .col_in  (col_in_fwd),
      .col_out (col_out_fwd),
      .busy    (busy_fwd),
      .done    (done_fwd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] xt(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] aa = a;
      logic [7:0] bb = b;
      for (int k = 0; k < 8; k++) begin
         if (bb[0]) p = p ^ aa;
         aa = xt(aa);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [31:0] mix_ref(input logic [31:0] col, input bit inv);
      logic [7:0] a [4];
      logic [7:0] c [4];
      logic [7:0] r;
      logic [31:0] res = 32'h0;
      for (int k = 0; k < 4; k++) a[k] = col[31-8*k -: 8];
      if (inv) begin c[0] = 8'h0E; c[1] = 8'h0B; c[2] = 8'h0D; c[3] = 8'h09; end
      else     begin c[0] = 8'h02; c[1] = 8'h03; c[2] = 8'h01; c[3] = 8'h01; end
      for (int i = 0; i < 4; i++) begin
         r = 8'h00;
         for (int j = 0; j < 4; j++) r = r ^ gmul(c[j], a[(i + j) % 4]);
         res[31-8*i -: 8] = r;
      end
      return res;
   endfunction

   // Scoreboard monitor: compares every done pulse against the oldest expected result.
   always @(negedge clk) begin
      if (rst) begin
         if (done_inv) begin
            chk("inv_done_one_cycle", {31'h0, prev_done_inv}, 32'h0);
            if (q_inv.size() == 0) chk("inv_unexpected_done", 32'h1, 32'h0);
            else chk("inv_col_out", col_out_inv, q_inv.pop_front());
         end
         if (done_fwd) begin
            chk("fwd_done_one_cycle", {31'h0, prev_done_fwd}, 32'h0);
            if (q_fwd.size() == 0) chk("fwd_unexpected_done", 32'h1, 32'h0);
            else chk("fwd_col_out", col_out_fwd, q_fwd.pop_front());
         end
      end
      prev_done_inv = done_inv;
      prev_done_fwd = done_fwd;
   end

   // Issues one column, checks busy throughout and that done arrives 81 edges after acceptance.
   task automatic run_col(input bit inv, input logic [31:0] col, input logic [31:0] exp);
      int  n;
      bit  seen;
      bit  busy_ok;
      @(negedge clk);
      if (inv) begin start_inv = 1'b1; col_in_inv = col; q_inv.push_back(exp); end
      else     begin start_fwd = 1'b1; col_in_fwd = col; q_fwd.push_back(exp); end
      @(posedge clk);
      #1;
      start_inv = 1'b0;
      start_fwd = 1'b0;
      chk("busy_after_accept", {31'h0, inv ? busy_inv : busy_fwd}, 32'h1);
      seen    = 1'b0;
      busy_ok = 1'b1;
      n       = 0;
      for (int c = 1; c <= 150 && !seen; c++) begin
         @(posedge clk);
         #1;
         if (inv ? done_inv : done_fwd) begin
            seen = 1'b1;
            n    = c;
         end else if (!(inv ? busy_inv : busy_fwd)) begin
            busy_ok = 1'b0;
         end
      end
      chk("done_seen", {31'h0, seen}, 32'h1);
      chk("latency", n, 81);
      chk("busy_held", {31'h0, busy_ok}, 32'h1);
   endtask

   initial begin
      logic [31:0] x;
      int          n;
      bit          busy_ok;
      checks        = 0;
      failures      = 0;
      prev_done_inv = 1'b0;
      prev_done_fwd = 1'b0;
      rst           = 1'b0;
      start_inv     = 1'b0;
      start_fwd     = 1'b0;
      col_in_inv    = 32'h0;
      col_in_fwd    = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_col_out", col_out_inv, 32'h0);
      chk("reset_busy", {31'h0, busy_inv}, 32'h0);
      chk("reset_done", {31'h0, done_inv}, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      run_col(1'b1, 32'h8E4DA1BC, 32'hDB135345);
      run_col(1'b1, 32'h9FDC589D, 32'hF20A225C);
      run_col(1'b1, 32'hD5D5D7D6, 32'hD4D4D4D5);
      run_col(1'b0, 32'hDB135345, 32'h8E4DA1BC);
      run_col(1'b0, 32'h01010101, 32'h01010101);
      run_col(1'b1, 32'h01010101, 32'h01010101);

      // start held high while the operand changes mid-operation
      @(negedge clk);
      start_inv  = 1'b1;
      col_in_inv = 32'h8E4DA1BC;
      q_inv.push_back(32'hDB135345);
      @(posedge clk);
      #1;
      col_in_inv = 32'hFFFFFFFF;
      busy_ok    = 1'b1;
      n          = 0;
      for (int c = 1; c <= 150 && n == 0; c++) begin
         @(posedge clk);
         #1;
         if (done_inv) n = c;
         else if (!busy_inv) busy_ok = 1'b0;
      end
      start_inv = 1'b0;
      chk("held_start_latency", n, 81);
      chk("held_start_busy", {31'h0, busy_ok}, 32'h1);
      repeat (3) @(posedge clk);
      #1;
      chk("held_start_no_requeue", {31'h0, busy_inv}, 32'h0);

      // asynchronous reset partway through a column
      @(negedge clk);
      start_inv  = 1'b1;
      col_in_inv = 32'h8E4DA1BC;
      @(posedge clk);
      #1;
      start_inv = 1'b0;
      repeat (36) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk("abort_col_out", col_out_inv, 32'h0);
      chk("abort_busy", {31'h0, busy_inv}, 32'h0);
      chk("abort_done", {31'h0, done_inv}, 32'h0);
      chk("abort_fwd_col_out", col_out_fwd, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      run_col(1'b1, 32'h8E4DA1BC, 32'hDB135345);

      // random columns against the reference model, plus inverse-of-forward round trip
      for (int r = 0; r < 40; r++) begin
         x = $urandom;
         run_col(1'b1, x, mix_ref(x, 1'b1));
         run_col(1'b0, x, mix_ref(x, 1'b0));
         run_col(1'b1, mix_ref(x, 1'b0), x);
      end

      repeat (5) @(posedge clk);
      chk("inv_queue_drained", q_inv.size(), 0);
      chk("fwd_queue_drained", q_fwd.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
